pie_modu: RTL and testbench

PIE modulator: the reader-side transmitter for the tag's PIE demodulator. It emits a complete Gen2-style forward-link frame on a single-bit, idle-high line, in this order: delimiter, data-0 (Tari), RTcal, optional TRcal, then data bits. Data bits arrive through a one-entry buffered valid/ready handshake. The block sits between the reader command builder and the RF envelope driver, and its waveform is what the tag demodulator measures rising edge to rising edge.

---
 rtl/pie_modu_if.sv | 22 ++
 rtl/pie_modu.sv | 199 +++++++++++++++++++
 tb/tb_pie_modu.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pie_modu_if.sv
// Bit-stream handshake between the reader command builder and the PIE modulator.
// One bit per transfer; a transfer happens when valid && ready.
interface pie_modu_if;
  logic valid;
  logic data;
  logic last;
  logic ready;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );
endinterface

// File: rtl/pie_modu.sv
// PIE modulator: emits delimiter, data-0, RTcal, optional TRcal and PIE-coded data bits
// on an idle-high line, fed by a one-entry buffered bit handshake.
module pie_modu #(
  parameter int unsigned CntW = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic            i_preamble,
  input  logic [CntW-1:0] i_delim,
  input  logic [CntW-1:0] i_tari,
  input  logic [CntW-1:0] i_rtcal,
  input  logic [CntW-1:0] i_trcal,
  input  logic [CntW-1:0] i_pw,
  pie_modu_if.slave       bus,
  output logic            o_pie,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_underrun,
  output logic            o_cfg_err
);

  typedef enum logic [2:0] {
    StIdle, StDelim, StTari, StRtcal, StTrcal, StData, StDone
  } state_e;

  typedef struct packed {
    logic [CntW-1:0] delim;
    logic [CntW-1:0] tari;
    logic [CntW-1:0] rtcal;
    logic [CntW-1:0] trcal;
    logic [CntW-1:0] pw;
    logic            pre;
  } cfg_t;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  cfg_t            cfg_q, cfg_d;
  logic            full_q, full_d;
  logic            buf_data_q, buf_data_d;
  logic            buf_last_q, buf_last_d;
  logic            sym_bit_q, sym_bit_d;
  logic            sym_last_q, sym_last_d;
  logic            underrun_q, underrun_d;
  logic            cfg_err_q, cfg_err_d;
  logic            pie_q, pie_d;

  logic            cfg_bad;
  logic [CntW-1:0] seg_len;
  logic            seg_end;
  logic            boundary;

  // Ordering guarantees every symbol is longer than its closing low pulse.
  assign cfg_bad = (i_pw == '0) || (i_delim == '0) || (i_pw >= i_tari) ||
                   (i_rtcal <= i_tari) || ((i_rtcal - i_tari) <= i_pw) ||
                   (i_preamble && (i_trcal <= i_rtcal));

  always_comb begin
    seg_len = '0;
    unique case (state_q)
      StDelim: seg_len = cfg_q.delim;
      StTari:  seg_len = cfg_q.tari;
      StRtcal: seg_len = cfg_q.rtcal;
      StTrcal: seg_len = cfg_q.trcal;
      StData:  seg_len = sym_bit_q ? (cfg_q.rtcal - cfg_q.tari) : cfg_q.tari;
      default: seg_len = '0;
    endcase
  end

  assign seg_end = (cnt_q == seg_len);

  always_comb begin
    pie_d = 1'b1;
    unique case (state_q)
      StDelim:                         pie_d = 1'b0;
      StTari, StRtcal, StTrcal, StData: pie_d = (cnt_q <= (seg_len - cfg_q.pw));
      default:                         pie_d = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CntW'(1);
    cfg_d      = cfg_q;
    full_d     = full_q;
    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
    sym_bit_d  = sym_bit_q;
    sym_last_d = sym_last_q;
    underrun_d = underrun_q;
    cfg_err_d  = 1'b0;
    boundary   = 1'b0;

    if (bus.valid && !full_q) begin
      full_d     = 1'b1;
      buf_data_d = bus.data;
      buf_last_d = bus.last;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = CntW'(1);
        if (i_start) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            cfg_d      = '{delim: i_delim, tari: i_tari, rtcal: i_rtcal, trcal: i_trcal,
                           pw: i_pw, pre: i_preamble};
            underrun_d = 1'b0;
            state_d    = StDelim;
          end
        end
      end
      StDelim: if (seg_end) begin
        state_d = StTari;
        cnt_d   = CntW'(1);
      end
      StTari: if (seg_end) begin
        state_d = StRtcal;
        cnt_d   = CntW'(1);
      end
      StRtcal: if (seg_end) begin
        if (cfg_q.pre) begin
          state_d = StTrcal;
          cnt_d   = CntW'(1);
        end else begin
          boundary = 1'b1;
        end
      end
      StTrcal: if (seg_end) boundary = 1'b1;
      StData: if (seg_end) begin
        if (sym_last_q) begin
          state_d = StDone;
          cnt_d   = CntW'(1);
        end else begin
          boundary = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = CntW'(1);
      end
      default: begin
        state_d = StIdle;
        cnt_d   = CntW'(1);
      end
    endcase

    // A bit arriving in an empty-buffer boundary cycle is kept for the next frame.
    if (boundary) begin
      cnt_d = CntW'(1);
      if (full_q) begin
        sym_bit_d  = buf_data_q;
        sym_last_d = buf_last_q;
        full_d     = 1'b0;
        state_d    = StData;
      end else begin
        underrun_d = 1'b1;
        state_d    = StDone;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= CntW'(1);
      cfg_q      <= '0;
      full_q     <= 1'b0;
      buf_data_q <= 1'b0;
      buf_last_q <= 1'b0;
      sym_bit_q  <= 1'b0;
      sym_last_q <= 1'b0;
      underrun_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      pie_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cfg_q      <= cfg_d;
      full_q     <= full_d;
      buf_data_q <= buf_data_d;
      buf_last_q <= buf_last_d;
      sym_bit_q  <= sym_bit_d;
      sym_last_q <= sym_last_d;
      underrun_q <= underrun_d;
      cfg_err_q  <= cfg_err_d;
      pie_q      <= pie_d;
    end
  end

  assign bus.ready  = ~full_q;
  assign o_pie      = pie_q;
  assign o_busy     = (state_q != StIdle);
  assign o_done     = (state_q == StDone);
  assign o_underrun = (state_q == StDone) && underrun_q;
  assign o_cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_pie_modu.sv
// Bench for pie_modu: directed and random frames compared cycle by cycle against a
// waveform built from the segment lengths.
module tb_pie_modu;
  localparam int unsigned CntW = 10;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_start, i_preamble;
  logic [CntW-1:0] i_delim, i_tari, i_rtcal, i_trcal, i_pw;
  logic            o_pie, o_busy, o_done, o_underrun, o_cfg_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pie_modu_if bus();

  pie_modu #(.CntW(CntW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (i_start),
    .i_preamble(i_preamble),
    .i_delim   (i_delim),
    .i_tari    (i_tari),
    .i_rtcal   (i_rtcal),
    .i_trcal   (i_trcal),
    .i_pw      (i_pw),
    .bus       (bus),
    .o_pie     (o_pie),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_underrun(o_underrun),
    .o_cfg_err (o_cfg_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int delim, input int tari, input int rtcal, input int trcal,
                         input int pw, input logic pre);
    i_delim    = CntW'(delim);
    i_tari     = CntW'(tari);
    i_rtcal    = CntW'(rtcal);
    i_trcal    = CntW'(trcal);
    i_pw       = CntW'(pw);
    i_preamble = pre;
  endtask

  // Called at a negedge; returns at the negedge of the first cycle with o_busy low again.
  task automatic run_frame(input int delim, input int tari, input int rtcal, input int trcal,
                           input int pw, input logic pre, input int nbits,
                           input logic [15:0] bits, input bit has_last, input int pre_cyc);
    int lens[$];
    int exp_q[$];
    lens = {tari, rtcal};
    if (pre) lens.push_back(trcal);
    for (int i = 0; i < nbits; i++) lens.push_back(bits[i] ? (rtcal - tari) : tari);
    for (int i = 0; i < delim; i++) exp_q.push_back(0);
    foreach (lens[s]) begin
      for (int i = 0; i < lens[s] - pw; i++) exp_q.push_back(1);
      for (int i = 0; i < pw; i++) exp_q.push_back(0);
    end

    fork
      begin
        for (int i = 0; i < nbits; i++) begin
          int w;
          w         = 0;
          bus.valid = 1'b1;
          bus.data  = bits[i];
          bus.last  = has_last && (i == nbits - 1);
          while (!bus.ready && w < 4000) begin
            @(negedge clk);
            w++;
          end
          if (w >= 4000) check("feed_timeout", 32'(w), 0);
          @(posedge clk);
          @(negedge clk);
        end
        bus.valid = 1'b0;
        bus.last  = 1'b0;
      end
      begin
        repeat (pre_cyc) @(negedge clk);
        set_cfg(delim, tari, rtcal, trcal, pw, pre);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("busy_after_start", o_busy, 1);
        check("no_cfg_err", o_cfg_err, 0);
        foreach (exp_q[k]) begin
          @(negedge clk);
          check("pie", o_pie, exp_q[k]);
          check("done", o_done, (k == exp_q.size() - 1));
          check("underrun", o_underrun, (k == exp_q.size() - 1) && !has_last);
        end
        @(negedge clk);
        check("pie_idle", o_pie, 1);
        check("busy_idle", o_busy, 0);
        check("done_idle", o_done, 0);
      end
    join
  endtask

  task automatic reject(input int delim, input int tari, input int rtcal, input int trcal,
                        input int pw, input logic pre);
    set_cfg(delim, tari, rtcal, trcal, pw, pre);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("rej_cfg_err", o_cfg_err, 1);
    check("rej_busy", o_busy, 0);
    check("rej_pie", o_pie, 1);
    @(negedge clk);
    check("rej_cfg_err_clear", o_cfg_err, 0);
    check("rej_busy2", o_busy, 0);
    check("rej_pie2", o_pie, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    i_start   = 1'b0;
    bus.valid = 1'b0;
    bus.data  = 1'b0;
    bus.last  = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_pie", o_pie, 1);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_underrun", o_underrun, 0);
    check("rst_cfg_err", o_cfg_err, 0);
    check("rst_ready", bus.ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Frame-sync, then preamble, bits 1 then 0 (last), first bit preloaded.
    run_frame(15, 12, 33, 60, 6, 1'b0, 2, 16'h0001, 1'b1, 1);
    run_frame(15, 12, 33, 60, 6, 1'b1, 2, 16'h0001, 1'b1, 1);

    reject(15, 12, 33, 60, 12, 1'b0);
    reject(15, 12, 33, 33, 6, 1'b1);
    reject(0, 12, 33, 60, 6, 1'b0);
    reject(15, 12, 18, 60, 6, 1'b0);

    // Underrun after one bit, and with no bit at all.
    run_frame(10, 8, 20, 30, 3, 1'b0, 1, 16'h0001, 1'b0, 1);
    run_frame(5, 6, 15, 30, 2, 1'b1, 0, 16'h0000, 1'b0, 0);

    // Back-to-back: second start issued as o_busy falls.
    run_frame(9, 10, 25, 40, 4, 1'b0, 3, 16'h0005, 1'b1, 1);
    run_frame(7, 10, 25, 40, 4, 1'b1, 4, 16'h000a, 1'b1, 0);

    // Reset during the RTcal low pulse.
    bus.valid = 1'b1;
    bus.data  = 1'b1;
    bus.last  = 1'b0;
    @(negedge clk);
    bus.valid = 1'b0;
    check("preload_full", bus.ready, 0);
    set_cfg(15, 12, 33, 60, 6, 1'b0);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (56) @(negedge clk);
    check("rtcal_low", o_pie, 0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_pie", o_pie, 1);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_done", o_done, 0);
    check("mid_rst_underrun", o_underrun, 0);
    check("mid_rst_cfg_err", o_cfg_err, 0);
    check("mid_rst_ready", bus.ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(15, 12, 33, 60, 6, 1'b0, 2, 16'h0001, 1'b1, 1);

    for (int r = 0; r < 8; r++) begin
      int pw, tari, rtcal, trcal, delim, nbits, pre_cyc;
      logic pre;
      bit   has_last;
      pw       = int'($urandom_range(1, 6));
      tari     = pw + int'($urandom_range(1, 10));
      rtcal    = tari + pw + int'($urandom_range(1, 15));
      trcal    = rtcal + int'($urandom_range(1, 30));
      delim    = int'($urandom_range(1, 16));
      nbits    = int'($urandom_range(1, 8));
      pre      = 1'($urandom_range(0, 1));
      has_last = ($urandom_range(0, 3) != 0);
      pre_cyc  = int'($urandom_range(0, 2));
      run_frame(delim, tari, rtcal, trcal, pw, pre, nbits, 16'($urandom), has_last, pre_cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
